// File: rtl/n64_vdemux.sv
// N64 digital video bus demultiplexer: splits nDSYNC-framed 4-cycle groups into
// sync nibble and R/G/B, emits a strobed pixel word and tracks line length.
module n64_vdemux #(
    parameter int color_width = 7,
    parameter int hcnt_width  = 10
) (
    input  logic                       VCLK,
    input  logic                       nRST,
    input  logic                       nDSYNC,
    input  logic [color_width-1:0]     D_i,
    input  logic [3:0]                 vinfo_i,
    output logic [3:0]                 Sync_pre,
    output logic [3:0]                 Sync_cur,
    output logic [3*color_width+3:0]   vdata_o,
    output logic                       pix_valid_o,
    output logic                       vmode_o,
    output logic                       n64_480i_o,
    output logic [hcnt_width-1:0]      hpix_len_o,
    output logic                       phase_err_o
);

    logic [color_width-1:0] r_red;
    logic [color_width-1:0] r_grn;
    logic                   r_got_r;
    logic                   r_got_g;
    logic [hcnt_width-1:0]  r_hcnt;

    logic [1:0] w_cnt;
    logic       w_sync_ev;
    logic       w_phase;
    logic       w_emit;
    logic       w_hs_rise;
    logic       w_hs_fall;

    always_comb begin
        w_cnt     = vinfo_i[3:2];
        w_sync_ev = ~nDSYNC;
        w_phase   = w_sync_ev & (w_cnt != 2'b00);
        w_emit    = nDSYNC & (w_cnt == 2'b11) & r_got_r & r_got_g;
        // nHSYNC edges are seen on the incoming nibble versus the held one
        w_hs_rise = w_sync_ev & ~Sync_cur[1] & D_i[1];
        w_hs_fall = w_sync_ev & Sync_cur[1] & ~D_i[1];
    end

    always_ff @(posedge VCLK) begin
        if (!nRST) begin
            Sync_pre    <= 4'hF;
            Sync_cur    <= 4'hF;
            vdata_o     <= {4'hF, {(3*color_width){1'b0}}};
            pix_valid_o <= 1'b0;
            phase_err_o <= 1'b0;
            vmode_o     <= 1'b0;
            n64_480i_o  <= 1'b1;
            hpix_len_o  <= '0;
            r_hcnt      <= '0;
            r_red       <= '0;
            r_grn       <= '0;
            r_got_r     <= 1'b0;
            r_got_g     <= 1'b0;
        end else begin
            pix_valid_o <= w_emit;
            phase_err_o <= w_phase;

            if (w_sync_ev) begin
                Sync_pre <= Sync_cur;
                Sync_cur <= D_i[3:0];
            end

            if (nDSYNC) begin
                case (w_cnt)
                    2'b01: begin
                        r_red   <= D_i;
                        r_got_r <= 1'b1;
                    end
                    2'b10: begin
                        r_grn   <= D_i;
                        r_got_g <= 1'b1;
                    end
                    2'b11: begin
                        r_got_r <= 1'b0;
                        r_got_g <= 1'b0;
                    end
                    default: ;
                endcase
            end else if (w_phase) begin
                r_got_r <= 1'b0;
                r_got_g <= 1'b0;
            end

            if (w_emit) begin
                vdata_o    <= {Sync_cur, r_red, r_grn, D_i};
                vmode_o    <= vinfo_i[1];
                n64_480i_o <= vinfo_i[0];
            end

            if (w_hs_fall)
                hpix_len_o <= r_hcnt;

            if (w_hs_rise)
                r_hcnt <= '0;
            else if (w_emit && (r_hcnt != '1))
                r_hcnt <= r_hcnt + hcnt_width'(1);
        end
    end

endmodule

// File: tb/tb_n64_vdemux.sv
// Directed bench for n64_vdemux: framing, pixel emit, phase faults, line length,
// mid-group reset and vinfo capture.
module tb_n64_vdemux;

    logic        VCLK;
    logic        nRST;
    logic        nDSYNC;
    logic [6:0]  D_i;
    logic [3:0]  vinfo_i;
    logic [3:0]  Sync_pre;
    logic [3:0]  Sync_cur;
    logic [24:0] vdata_o;
    logic        pix_valid_o;
    logic        vmode_o;
    logic        n64_480i_o;
    logic [9:0]  hpix_len_o;
    logic        phase_err_o;

    int unsigned total;
    int unsigned bad;

    n64_vdemux #(.color_width(7), .hcnt_width(10)) dut (
        .VCLK        (VCLK),
        .nRST        (nRST),
        .nDSYNC      (nDSYNC),
        .D_i         (D_i),
        .vinfo_i     (vinfo_i),
        .Sync_pre    (Sync_pre),
        .Sync_cur    (Sync_cur),
        .vdata_o     (vdata_o),
        .pix_valid_o (pix_valid_o),
        .vmode_o     (vmode_o),
        .n64_480i_o  (n64_480i_o),
        .hpix_len_o  (hpix_len_o),
        .phase_err_o (phase_err_o)
    );

    initial VCLK = 1'b0;
    always #5 VCLK = ~VCLK;

    // Apply one cycle of inputs; returns #1 after the capturing edge.
    task automatic step(input logic nd, input logic [1:0] cnt, input logic [6:0] d,
                        input logic [1:0] vi);
        nDSYNC  = nd;
        vinfo_i = {cnt, vi};
        D_i     = d;
        @(posedge VCLK);
        #1;
    endtask

    task automatic run_group(input logic [3:0] s, input logic [6:0] r, input logic [6:0] g,
                             input logic [6:0] b, input logic [1:0] vi_b,
                             output logic strobed, output int unsigned early);
        early = 0;
        step(1'b0, 2'b00, {3'b000, s}, 2'b00);
        if (pix_valid_o) early++;
        step(1'b1, 2'b01, r, 2'b00);
        if (pix_valid_o) early++;
        step(1'b1, 2'b10, g, 2'b00);
        if (pix_valid_o) early++;
        step(1'b1, 2'b11, b, vi_b);
        strobed = pix_valid_o;
    endtask

    task automatic test_reset;
        nRST = 1'b0;
        step(1'b1, 2'b00, 7'h00, 2'b00);
        step(1'b1, 2'b00, 7'h00, 2'b00);
        total++; if (Sync_pre !== 4'hF) begin bad++; $display("FAIL reset_sync_pre got=%h exp=F", Sync_pre); end
        total++; if (Sync_cur !== 4'hF) begin bad++; $display("FAIL reset_sync_cur got=%h exp=F", Sync_cur); end
        total++; if (vdata_o !== 25'h1E00000) begin bad++; $display("FAIL reset_vdata got=%h exp=1e00000", vdata_o); end
        total++; if (pix_valid_o !== 1'b0 || phase_err_o !== 1'b0) begin bad++; $display("FAIL reset_strobes got=%b%b exp=00", pix_valid_o, phase_err_o); end
        total++; if (vmode_o !== 1'b0 || n64_480i_o !== 1'b1) begin bad++; $display("FAIL reset_vinfo got=%b%b exp=01", vmode_o, n64_480i_o); end
        total++; if (hpix_len_o !== 10'd0) begin bad++; $display("FAIL reset_hpix got=%0d exp=0", hpix_len_o); end
        nRST = 1'b1;
    endtask

    task automatic test_pixel;
        logic        st;
        int unsigned early;
        logic [24:0] exp;
        run_group(4'hF, 7'h11, 7'h22, 7'h33, 2'b00, st, early);
        exp = {4'hF, 7'h11, 7'h22, 7'h33};
        total++; if (early != 0) begin bad++; $display("FAIL pix1_early got=%0d exp=0", early); end
        total++; if (st !== 1'b1) begin bad++; $display("FAIL pix1_strobe got=%b exp=1", st); end
        total++; if (vdata_o !== exp) begin bad++; $display("FAIL pix1_vdata got=%h exp=%h", vdata_o, exp); end
        total++; if (phase_err_o !== 1'b0) begin bad++; $display("FAIL pix1_perr got=%b exp=0", phase_err_o); end
        run_group(4'hF, 7'h7F, 7'h00, 7'h55, 2'b00, st, early);
        exp = {4'hF, 7'h7F, 7'h00, 7'h55};
        total++; if (early != 0 || st !== 1'b1) begin bad++; $display("FAIL pix2_strobe got=%0d/%b exp=0/1", early, st); end
        total++; if (vdata_o !== exp) begin bad++; $display("FAIL pix2_vdata got=%h exp=%h", vdata_o, exp); end
        step(1'b0, 2'b00, 7'h0F, 2'b00);
        total++; if (pix_valid_o !== 1'b0 || vdata_o !== exp) begin bad++; $display("FAIL pix_hold got=%b/%h exp=0/%h", pix_valid_o, vdata_o, exp); end
        step(1'b1, 2'b01, 7'h01, 2'b00);
        step(1'b1, 2'b10, 7'h02, 2'b00);
        step(1'b1, 2'b11, 7'h03, 2'b00);
    endtask

    task automatic test_sync_pair;
        logic        st;
        int unsigned early;
        logic [24:0] exp;
        run_group(4'hF, 7'h01, 7'h02, 7'h03, 2'b00, st, early);
        step(1'b0, 2'b00, 7'h05, 2'b00);
        total++; if (Sync_pre !== 4'hF || Sync_cur !== 4'h5) begin bad++; $display("FAIL sync_pair got=%h/%h exp=F/5", Sync_pre, Sync_cur); end
        step(1'b1, 2'b01, 7'h0A, 2'b00);
        step(1'b1, 2'b10, 7'h0B, 2'b00);
        step(1'b1, 2'b11, 7'h0C, 2'b00);
        exp = {4'h5, 7'h0A, 7'h0B, 7'h0C};
        total++; if (pix_valid_o !== 1'b1 || vdata_o !== exp) begin bad++; $display("FAIL sync_pair_vdata got=%b/%h exp=1/%h", pix_valid_o, vdata_o, exp); end
    endtask

    task automatic test_phase;
        logic        st;
        int unsigned early;
        logic [24:0] exp;
        step(1'b0, 2'b00, 7'h0F, 2'b00);
        total++; if (phase_err_o !== 1'b0) begin bad++; $display("FAIL phase_nominal got=%b exp=0", phase_err_o); end
        step(1'b1, 2'b01, 7'h21, 2'b00);
        step(1'b0, 2'b10, 7'h0E, 2'b00);
        total++; if (phase_err_o !== 1'b1) begin bad++; $display("FAIL phase_pulse got=%b exp=1", phase_err_o); end
        total++; if (Sync_cur !== 4'hE) begin bad++; $display("FAIL phase_sync got=%h exp=E", Sync_cur); end
        step(1'b1, 2'b11, 7'h23, 2'b00);
        total++; if (phase_err_o !== 1'b0 || pix_valid_o !== 1'b0) begin bad++; $display("FAIL phase_after got=%b/%b exp=0/0", phase_err_o, pix_valid_o); end
        run_group(4'hF, 7'h31, 7'h32, 7'h33, 2'b00, st, early);
        exp = {4'hF, 7'h31, 7'h32, 7'h33};
        total++; if (st !== 1'b1 || vdata_o !== exp || phase_err_o !== 1'b0) begin bad++; $display("FAIL phase_recover got=%b/%h/%b exp=1/%h/0", st, vdata_o, phase_err_o, exp); end
    endtask

    task automatic test_vinfo;
        logic        st;
        int unsigned early;
        run_group(4'hF, 7'h01, 7'h02, 7'h03, 2'b10, st, early);
        total++; if (st !== 1'b1 || vmode_o !== 1'b1 || n64_480i_o !== 1'b0) begin bad++; $display("FAIL vinfo_capture got=%b/%b%b exp=1/10", st, vmode_o, n64_480i_o); end
        step(1'b0, 2'b00, 7'h0F, 2'b01);
        total++; if (vmode_o !== 1'b1 || n64_480i_o !== 1'b0) begin bad++; $display("FAIL vinfo_hold got=%b%b exp=10", vmode_o, n64_480i_o); end
        step(1'b1, 2'b01, 7'h04, 2'b00);
        step(1'b1, 2'b10, 7'h05, 2'b00);
        step(1'b1, 2'b11, 7'h06, 2'b01);
        total++; if (vmode_o !== 1'b0 || n64_480i_o !== 1'b1) begin bad++; $display("FAIL vinfo_capture2 got=%b%b exp=01", vmode_o, n64_480i_o); end
    endtask

    task automatic test_hlen;
        logic        st;
        int unsigned early;
        int unsigned strobes;
        int unsigned lens [3];
        logic [9:0]  exp_len [3];
        lens[0] = 640;  exp_len[0] = 10'd640;
        lens[1] = 1100; exp_len[1] = 10'd1023;
        lens[2] = 3;    exp_len[2] = 10'd3;
        run_group(4'hD, 7'h01, 7'h02, 7'h03, 2'b00, st, early);
        for (int k = 0; k < 3; k++) begin
            strobes = 0;
            for (int unsigned n = 0; n < lens[k]; n++) begin
                run_group(4'hF, 7'(n), 7'h02, 7'h03, 2'b00, st, early);
                if (st && early == 0) strobes++;
            end
            total++; if (strobes != lens[k]) begin bad++; $display("FAIL hlen_strobes%0d got=%0d exp=%0d", k, strobes, lens[k]); end
            run_group(4'hD, 7'h01, 7'h02, 7'h03, 2'b00, st, early);
            total++; if (hpix_len_o !== exp_len[k]) begin bad++; $display("FAIL hlen%0d got=%0d exp=%0d", k, hpix_len_o, exp_len[k]); end
        end
    endtask

    task automatic test_reset_mid;
        logic        st;
        int unsigned early;
        logic [24:0] exp;
        step(1'b0, 2'b00, 7'h05, 2'b00);
        step(1'b1, 2'b01, 7'h41, 2'b00);
        step(1'b1, 2'b10, 7'h42, 2'b00);
        nRST = 1'b0;
        step(1'b1, 2'b10, 7'h42, 2'b00);
        nRST = 1'b1;
        total++; if (Sync_pre !== 4'hF || Sync_cur !== 4'hF) begin bad++; $display("FAIL rstmid_sync got=%h/%h exp=F/F", Sync_pre, Sync_cur); end
        total++; if (vdata_o !== 25'h1E00000 || hpix_len_o !== 10'd0) begin bad++; $display("FAIL rstmid_vals got=%h/%0d exp=1e00000/0", vdata_o, hpix_len_o); end
        total++; if (vmode_o !== 1'b0 || n64_480i_o !== 1'b1) begin bad++; $display("FAIL rstmid_vinfo got=%b%b exp=01", vmode_o, n64_480i_o); end
        step(1'b1, 2'b11, 7'h43, 2'b00);
        total++; if (pix_valid_o !== 1'b0 || vdata_o !== 25'h1E00000) begin bad++; $display("FAIL rstmid_nostrobe got=%b/%h exp=0/1e00000", pix_valid_o, vdata_o); end
        run_group(4'hF, 7'h51, 7'h52, 7'h53, 2'b00, st, early);
        exp = {4'hF, 7'h51, 7'h52, 7'h53};
        total++; if (st !== 1'b1 || vdata_o !== exp) begin bad++; $display("FAIL rstmid_recover got=%b/%h exp=1/%h", st, vdata_o, exp); end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        nRST    = 1'b0;
        nDSYNC  = 1'b1;
        D_i     = '0;
        vinfo_i = '0;
        test_reset;
        test_pixel;
        test_sync_pair;
        test_phase;
        test_vinfo;
        test_hlen;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
